// File: rtl/radix5_stride_gather.sv
// Radix-5 stride gather: ping-pong frame buffer of N=5*M complex samples,
// written in natural order, read as groups {x[m], x[m+M], .. x[m+4M]}.
// Ports: clk, rst (async, active-high)
//   in_valid/in_ready/in_re/in_im    : one sample per cycle in
//   out_valid/out_ready/out_last/out_idx, x0..x4 re/im : one group out
module radix5_stride_gather #(
  parameter int WIDTH = 15,
  parameter int M     = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_re,
  input  logic [WIDTH-1:0]                 in_im,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic [((M>1)?$clog2(M):1)-1:0]   out_idx,
  output logic [WIDTH-1:0]                 x0_re,
  output logic [WIDTH-1:0]                 x1_re,
  output logic [WIDTH-1:0]                 x2_re,
  output logic [WIDTH-1:0]                 x3_re,
  output logic [WIDTH-1:0]                 x4_re,
  output logic [WIDTH-1:0]                 x0_im,
  output logic [WIDTH-1:0]                 x1_im,
  output logic [WIDTH-1:0]                 x2_im,
  output logic [WIDTH-1:0]                 x3_im,
  output logic [WIDTH-1:0]                 x4_im
);

  localparam int N  = 5 * M;
  localparam int CW = $clog2(N);
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  logic [WIDTH-1:0] r_mem_re [2][N];
  logic [WIDTH-1:0] r_mem_im [2][N];

  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [CW-1:0] r_wr_cnt;
  logic [IW-1:0] r_rd_cnt;

  logic          w_wr_fire;
  logic          w_wr_wrap;
  logic          w_out_valid;
  logic          w_rd_fire;
  logic          w_rd_wrap;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;
  logic [CW-1:0] w_addr [5];

  assign in_ready    = ~r_full[r_wr_bank];
  assign w_wr_fire   = in_valid & ~r_full[r_wr_bank];
  assign w_wr_wrap   = (r_wr_cnt == CW'(N - 1));
  assign w_out_valid = r_full[r_rd_bank];
  assign w_rd_fire   = w_out_valid & out_ready;
  assign w_rd_wrap   = (r_rd_cnt == IW'(M - 1));

  // Write side only ever sets the bank it fills; read side only
  // clears the bank it drains, and those are never the same bank.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_wr_fire && w_wr_wrap) w_set[r_wr_bank] = 1'b1;
    if (w_rd_fire && w_rd_wrap) w_clr[r_rd_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
    end else begin
      if (w_wr_fire) begin
        if (w_wr_wrap) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= r_wr_cnt + 1'b1;
        end
      end
      if (w_rd_fire) begin
        if (w_rd_wrap) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_cnt  <= r_rd_cnt + 1'b1;
        end
      end
      r_full <= (r_full | w_set) & ~w_clr;
    end
  end

  // Sample storage carries no reset; the full flags gate its visibility.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem_re[r_wr_bank][r_wr_cnt] <= in_re;
      r_mem_im[r_wr_bank][r_wr_cnt] <= in_im;
    end
  end

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      w_addr[k] = CW'(r_rd_cnt) + CW'(k * M);
    end
  end

  // The read bank is never written while full, so a stalled group
  // stays stable without any output register.
  always_comb begin
    out_valid = w_out_valid;
    out_last  = w_out_valid & w_rd_wrap;
    out_idx   = '0;
    x0_re = '0; x1_re = '0; x2_re = '0; x3_re = '0; x4_re = '0;
    x0_im = '0; x1_im = '0; x2_im = '0; x3_im = '0; x4_im = '0;
    if (w_out_valid) begin
      out_idx = r_rd_cnt;
      x0_re = r_mem_re[r_rd_bank][w_addr[0]];
      x1_re = r_mem_re[r_rd_bank][w_addr[1]];
      x2_re = r_mem_re[r_rd_bank][w_addr[2]];
      x3_re = r_mem_re[r_rd_bank][w_addr[3]];
      x4_re = r_mem_re[r_rd_bank][w_addr[4]];
      x0_im = r_mem_im[r_rd_bank][w_addr[0]];
      x1_im = r_mem_im[r_rd_bank][w_addr[1]];
      x2_im = r_mem_im[r_rd_bank][w_addr[2]];
      x3_im = r_mem_im[r_rd_bank][w_addr[3]];
      x4_im = r_mem_im[r_rd_bank][w_addr[4]];
    end
  end

endmodule

// File: tb/tb_radix5_stride_gather.sv
// Testbench for radix5_stride_gather (WIDTH=15, M=12).
// Directed vectors, a group table and a sample-history reference model.
module tb_radix5_stride_gather;

  localparam int W = 15;
  localparam int M = 12;
  localparam int N = 5 * M;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_re;
  logic [W-1:0]  in_im;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [3:0]    out_idx;
  logic [W-1:0]  x0_re, x1_re, x2_re, x3_re, x4_re;
  logic [W-1:0]  x0_im, x1_im, x2_im, x3_im, x4_im;

  radix5_stride_gather #(.WIDTH(W), .M(M)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_idx(out_idx),
    .x0_re(x0_re), .x1_re(x1_re), .x2_re(x2_re),
    .x3_re(x3_re), .x4_re(x4_re),
    .x0_im(x0_im), .x1_im(x1_im), .x2_im(x2_im),
    .x3_im(x3_im), .x4_im(x4_im)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int               m;
    logic [4:0][14:0] re;
    logic [4:0][14:0] im;
    logic             last;
  } grp_t;

  grp_t tbl [3];

  // Reference model: history of accepted samples since reset.
  logic [W-1:0]     sre [1024];
  logic [W-1:0]     sim [1024];
  int               acc = 0;
  int               fo = 0;
  int               og = 0;
  int               groups = 0;
  int               lasts = 0;
  logic             stalled = 1'b0;
  logic [159:0]     held;
  logic [4:0][14:0] ar, ai, er, ei;
  logic [159:0]     cur, expv;

  always @(negedge clk) begin
    ar  = {x4_re, x3_re, x2_re, x1_re, x0_re};
    ai  = {x4_im, x3_im, x2_im, x1_im, x0_im};
    cur = 160'({out_valid, out_last, out_idx, ar, ai});
    if (rst) begin
      acc = 0; fo = 0; og = 0; stalled = 1'b0;
    end else begin
      if (stalled) chk("stall_hold", cur, held);
      if (in_valid && in_ready) begin
        sre[10'(acc)] = in_re;
        sim[10'(acc)] = in_im;
        acc++;
      end
      if (out_valid && out_ready) begin
        for (int k = 0; k < 5; k++) begin
          er[k] = sre[10'(fo * N + og + k * M)];
          ei[k] = sim[10'(fo * N + og + k * M)];
        end
        expv = 160'({1'b1, og == M - 1, 4'(og), er, ei});
        chk("group", cur, expv);
        groups++;
        og++;
        if (og == M) begin
          og = 0; fo++; lasts++;
        end
      end
      stalled = out_valid && !out_ready;
      held    = cur;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input int base,
                      input bit tog, output int lows);
    int  k;
    int  c;
    bit  a;
    k = 0; c = 0; lows = 0;
    while (k < n && c < 1000) begin
      in_valid = 1'b1;
      in_re    = 15'(base + k);
      in_im    = 15'(-(base + k));
      if (tog) out_ready = ~out_ready;
      a = in_ready;
      if (!a) lows++;
      cyc();
      if (a) k++;
      c++;
    end
    in_valid = 1'b0;
    chk("feed_bound", 160'(k), 160'(n));
  endtask

  task automatic wait_idle(input bit tog);
    int c;
    c = 0;
    while (out_valid && c < 300) begin
      if (tog) out_ready = ~out_ready;
      else out_ready = 1'b1;
      cyc();
      c++;
    end
    chk("drain_bound", 160'(out_valid), 160'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   lows;
    int   hs;
    int   a0;
    int   g0;
    int   l0;
    int   nacc;
    bit   early;
    bit   done;

    tbl[0].m = 0;
    tbl[0].re = {15'd48, 15'd36, 15'd24, 15'd12, 15'd0};
    tbl[0].im = {15'h7FD0, 15'h7FDC, 15'h7FE8, 15'h7FF4, 15'h0};
    tbl[0].last = 1'b0;
    tbl[1].m = 5;
    tbl[1].re = {15'd53, 15'd41, 15'd29, 15'd17, 15'd5};
    tbl[1].im = {15'h7FCB, 15'h7FD7, 15'h7FE3, 15'h7FEF, 15'h7FFB};
    tbl[1].last = 1'b0;
    tbl[2].m = 11;
    tbl[2].re = {15'd59, 15'd47, 15'd35, 15'd23, 15'd11};
    tbl[2].im = {15'h7FC5, 15'h7FD1, 15'h7FDD, 15'h7FE9, 15'h7FF5};
    tbl[2].last = 1'b1;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", 160'(in_ready), 160'(1));
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_last_idx", 160'({out_last, out_idx}), 160'(0));
    chk("rst_x", 160'({x0_re, x4_re, x0_im, x4_im}), 160'(0));

    // Single frame, re=k im=-k, downstream always ready.
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_re = 15'(k);
      in_im = 15'(-k);
      if (k == N - 1) chk("no_early_valid", 160'(out_valid), 160'(0));
      cyc();
    end
    in_valid = 1'b0;
    chk("valid_after_60", 160'(out_valid), 160'(1));
    for (int c = 0; c < M; c++) begin
      for (int t = 0; t < 3; t++) begin
        if (32'(out_idx) == tbl[t].m) begin
          chk($sformatf("tbl_g%0d", tbl[t].m),
              160'({out_valid, out_last,
                    x4_re, x3_re, x2_re, x1_re, x0_re,
                    x4_im, x3_im, x2_im, x1_im, x0_im}),
              160'({1'b1, tbl[t].last, tbl[t].re, tbl[t].im}));
        end
      end
      cyc();
    end
    chk("valid_drop_12", 160'(out_valid), 160'(0));

    // Both banks fill with downstream stalled.
    out_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 300; c++) begin
      if (!in_ready) break;
      in_valid = 1'b1;
      in_re = 15'(200 + nacc);
      in_im = 15'(-(200 + nacc));
      cyc();
      nacc++;
    end
    chk("accepts_120", 160'(nacc), 160'(120));
    a0 = acc;
    in_re = 15'h1234;
    repeat (3) cyc();
    chk("full_ignores", 160'(acc - a0), 160'(0));
    in_valid = 1'b0;

    out_ready = 1'b1;
    hs = 0; early = 1'b0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (out_valid && out_ready) hs++;
      cyc();
      if (hs == M) done = 1'b1;
      else if (in_ready) early = 1'b1;
    end
    chk("release_bound", 160'(done), 160'(1));
    chk("no_early_ready", 160'(early), 160'(0));
    chk("ready_after_12", 160'(in_ready), 160'(1));
    chk("frame2_next", 160'({out_valid, out_idx}), 160'({1'b1, 4'd0}));
    feed(N, 400, 1'b0, lows);
    wait_idle(1'b0);

    // Three back-to-back frames, downstream always ready.
    g0 = groups; l0 = lasts;
    out_ready = 1'b1;
    feed(3 * N, 500, 1'b0, lows);
    chk("cont_no_stall", 160'(lows), 160'(0));
    wait_idle(1'b0);
    chk("cont_groups", 160'(groups - g0), 160'(36));
    chk("cont_lasts", 160'(lows + lasts - l0), 160'(3));

    // Downstream ready toggling every cycle.
    g0 = groups;
    out_ready = 1'b0;
    feed(N, 700, 1'b1, lows);
    wait_idle(1'b1);
    chk("toggle_groups", 160'(groups - g0), 160'(M));

    // Reset in the middle of a frame.
    out_ready = 1'b1;
    feed(30, 800, 1'b0, lows);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 160'(out_valid), 160'(0));
    chk("mid_rst_ready", 160'(in_ready), 160'(1));
    cyc();
    rst = 1'b0;
    cyc();
    chk("no_stale", 160'(out_valid), 160'(0));
    out_ready = 1'b0;
    feed(N, 100, 1'b0, lows);
    chk("post_rst_g0",
        160'({out_valid, x4_re, x3_re, x2_re, x1_re, x0_re}),
        160'({1'b1, 15'd148, 15'd136, 15'd124, 15'd112, 15'd100}));
    wait_idle(1'b0);

    // Extreme sample values.
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_re = 15'(k);
      in_im = 15'(k);
      if (k == 3) begin
        in_re = 15'h4000; in_im = 15'h3FFF;
      end
      if (k == 3 + 4 * M) begin
        in_re = 15'h3FFF; in_im = 15'h4000;
      end
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    out_ready = 1'b0;
    chk("ext_idx", 160'(out_idx), 160'(3));
    chk("ext_x0", 160'({x0_re, x0_im}), 160'({15'h4000, 15'h3FFF}));
    chk("ext_x4", 160'({x4_re, x4_im}), 160'({15'h3FFF, 15'h4000}));
    cyc();
    wait_idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
